// File: rtl/uart_packetizer.sv
// Purpose: frames SAMPLE_W-bit samples into SYNC/SEQ/payload/CHECK byte packets for the UART TX FIFO.
// Latency: SYNC byte is written the cycle after the first sample is accepted in IDLE; then one byte per unstalled cycle.
// Backpressure: fifo_full_i stalls the current byte (held on data_o); sample_ready_o only in IDLE/WAIT.
// Build option: define PKT_CRC8_EN to make CHECK a CRC-8 (poly 0x07) instead of an additive sum.
module uart_packetizer #(
   parameter int          SAMPLE_W        = 16,
   parameter int          SAMPLES_PER_PKT = 4,
   parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] sample_i,
   input  logic                sample_valid_i,
   output logic                sample_ready_o,
   output logic [7:0]          data_o,
   output logic                wr_en_o,
   input  logic                fifo_full_i,
   output logic                busy_o,
   output logic [7:0]          seq_o
);

   localparam int         BYTES    = SAMPLE_W / 8;
   localparam logic [1:0] IDX_TOP  = 2'(BYTES - 1);
   localparam logic [7:0] CNT_LAST = 8'(SAMPLES_PER_PKT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_SEQ, S_PAYLOAD, S_WAIT, S_CHECK
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          seq_q;
   logic [7:0]          cnt_q;
   logic [1:0]          idx_q;
   logic [SAMPLE_W-1:0] hold_q;
   logic [7:0]          acc_q;

   logic [7:0]          emit_byte;
   logic                is_emit;
   logic                ready_c;
   logic [7:0]          pay_byte;

   // Folds one emitted byte into the running CHECK value.
   function automatic logic [7:0] check_upd(input logic [7:0] acc, input logic [7:0] b);
`ifdef PKT_CRC8_EN
      logic [7:0] c;
      c = acc ^ b;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
      end
      return c;
`else
      return acc + b;
`endif
   endfunction

   assign pay_byte = hold_q[8*idx_q +: 8];

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode and per-state byte selection.
   always_comb begin
      state_d   = state_q;
      emit_byte = 8'h00;
      is_emit   = 1'b0;
      ready_c   = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready_c = 1'b1;
            if (sample_valid_i) state_d = S_SYNC;
         end
         S_SYNC: begin
            is_emit   = 1'b1;
            emit_byte = SYNC_BYTE;
            if (!fifo_full_i) state_d = S_SEQ;
         end
         S_SEQ: begin
            is_emit   = 1'b1;
            emit_byte = seq_q;
            if (!fifo_full_i) state_d = S_PAYLOAD;
         end
         S_PAYLOAD: begin
            is_emit   = 1'b1;
            emit_byte = pay_byte;
            if (!fifo_full_i && idx_q == 2'd0)
               state_d = (cnt_q == CNT_LAST) ? S_CHECK : S_WAIT;
         end
         S_WAIT: begin
            ready_c = 1'b1;
            if (sample_valid_i) state_d = S_PAYLOAD;
         end
         S_CHECK: begin
            is_emit   = 1'b1;
            emit_byte = acc_q;
            if (!fifo_full_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sample holding, byte index, sample count, check accumulator and sequence number.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq_q  <= 8'h00;
         cnt_q  <= 8'h00;
         idx_q  <= 2'd0;
         hold_q <= '0;
         acc_q  <= 8'h00;
      end else begin
         case (state_q)
            S_IDLE: if (sample_valid_i) begin
               hold_q <= sample_i;
               acc_q  <= 8'h00;
               cnt_q  <= 8'h00;
            end
            S_SEQ: if (!fifo_full_i) begin
               acc_q <= check_upd(acc_q, seq_q);
               idx_q <= IDX_TOP;
            end
            S_PAYLOAD: if (!fifo_full_i) begin
               acc_q <= check_upd(acc_q, pay_byte);
               if (idx_q != 2'd0)         idx_q <= idx_q - 2'd1;
               else if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 8'd1;
            end
            S_WAIT: if (sample_valid_i) begin
               hold_q <= sample_i;
               idx_q  <= IDX_TOP;
            end
            S_CHECK: if (!fifo_full_i) seq_q <= seq_q + 8'd1;
            default: ;
         endcase
      end
   end

   // Outputs are forced quiet while reset is held, independent of the clock.
   assign sample_ready_o = ready_c & ~rst;
   assign wr_en_o        = is_emit & ~fifo_full_i & ~rst;
   assign data_o         = rst ? 8'h00 : emit_byte;
   assign busy_o         = (state_q != S_IDLE);
   assign seq_o          = seq_q;

endmodule

// File: tb/tb_uart_packetizer.sv
// Bench for uart_packetizer: directed framing, stall, sequence wrap, continuous-valid and mid-packet reset
// scenarios with random samples and random FIFO-full, all checked against a packet-level reference model.
module tb_uart_packetizer;

   localparam int SW      = 16;
   localparam int SPP     = 2;
   localparam int BYTES   = SW / 8;
   localparam int PKT_LEN = 2 + BYTES * SPP + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [SW-1:0] sample_i;
   logic          sample_valid_i;
   logic          sample_ready_o;
   logic [7:0]    data_o;
   logic          wr_en_o;
   logic          fifo_full_i;
   logic          busy_o;
   logic [7:0]    seq_o;

   int total = 0;
   int bad   = 0;

   logic [7:0]    got_q[$];
   logic [7:0]    exp_q[$];
   logic [SW-1:0] acc_q[$];
   logic [SW-1:0] sent_q[$];
   logic          stop_full;

   uart_packetizer #(.SAMPLE_W(SW), .SAMPLES_PER_PKT(SPP), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
      .sample_ready_o(sample_ready_o), .data_o(data_o), .wr_en_o(wr_en_o),
      .fifo_full_i(fifo_full_i), .busy_o(busy_o), .seq_o(seq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Byte and transfer capture, plus per-cycle handshake invariants.
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en_o) got_q.push_back(data_o);
         if (sample_valid_i && sample_ready_o) acc_q.push_back(sample_i);
         if (sample_ready_o) chk("ready_cycle_writes", {31'b0, wr_en_o}, 32'd0);
         if (!busy_o) chk("idle_ready", {31'b0, sample_ready_o}, 32'd1);
      end
   end

   function automatic logic [7:0] model_check(input logic [7:0] msg[$]);
      int         sum = 0;
      logic [7:0] r = 8'h00;
      logic       fb;
`ifdef PKT_CRC8_EN
      foreach (msg[i]) begin
         for (int b = 7; b >= 0; b--) begin
            fb = r[7] ^ msg[i][b];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
         end
      end
      sum = int'(r);
`else
      foreach (msg[i]) sum += int'(msg[i]);
`endif
      return 8'(sum);
   endfunction

   task automatic build_expected();
      logic [7:0]    seq = 8'h00;
      logic [7:0]    msg[$];
      logic [SW-1:0] v;
      exp_q.delete();
      for (int p = 0; p < acc_q.size() / SPP; p++) begin
         msg.delete();
         msg.push_back(seq);
         for (int s = 0; s < SPP; s++) begin
            v = acc_q[p*SPP + s];
            for (int b = BYTES - 1; b >= 0; b--) msg.push_back(v[8*b +: 8]);
         end
         exp_q.push_back(8'hA5);
         foreach (msg[i]) exp_q.push_back(msg[i]);
         exp_q.push_back(model_check(msg));
         seq = seq + 8'd1;
      end
   endtask

   function automatic logic [7:0] got_at(input int i);
      if (i < got_q.size()) return got_q[i];
      return 8'hxx;
   endfunction

   // Whole byte stream since reset against the model; reports index+1 of first difference (0 = none).
   task automatic check_stream(input string tag);
      int mism = -1;
      int n;
      build_expected();
      chk({tag, "_len"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (mism < 0 && got_q[i] !== exp_q[i]) mism = i;
      if (mism >= 0) $display("  %s: byte %0d got %h want %h", tag, mism, got_q[mism], exp_q[mism]);
      chk({tag, "_first_diff"}, mism + 1, 32'd0);
   endtask

   task automatic check_samples(input string tag);
      int mism = -1;
      chk({tag, "_count"}, acc_q.size(), sent_q.size());
      for (int i = 0; i < acc_q.size() && i < sent_q.size(); i++)
         if (mism < 0 && acc_q[i] !== sent_q[i]) mism = i;
      chk({tag, "_first_diff"}, mism + 1, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sample_valid_i = 1'b0;
      fifo_full_i = 1'b0;
      sample_i = '0;
      got_q.delete(); acc_q.delete(); sent_q.delete();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'b0, sample_ready_o}, 32'd0);
      chk("rst_wr_en", {31'b0, wr_en_o}, 32'd0);
      chk("rst_data",  {24'b0, data_o}, 32'd0);
      chk("rst_busy",  {31'b0, busy_o}, 32'd0);
      chk("rst_seq",   {24'b0, seq_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Called just after a rising edge; returns just after the edge that took the sample.
   task automatic send_sample(input logic [SW-1:0] s);
      int   n = 0;
      logic took = 1'b0;
      sent_q.push_back(s);
      sample_i = s;
      sample_valid_i = 1'b1;
      while (!took && n < 200) begin
         @(negedge clk);
         took = sample_ready_o;
         n++;
         if (!took) begin @(posedge clk); #1; end
      end
      chk("send_accept", {31'b0, took}, 32'd1);
      @(posedge clk); #1;
      sample_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int nbytes);
      int n = 0;
      while ((got_q.size() < nbytes || busy_o) && n < 20000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wait_done_bytes", got_q.size(), nbytes);
   endtask

   task automatic random_packets(input int npkt, input int full_pct);
      int base = got_q.size();
      stop_full = 1'b0;
      fork
         begin
            for (int i = 0; i < npkt * SPP; i++) begin
               repeat ($urandom_range(2)) begin @(posedge clk); #1; end
               send_sample(SW'($urandom));
            end
            wait_done(base + npkt * PKT_LEN);
            stop_full = 1'b1;
         end
         begin
            while (!stop_full) begin
               fifo_full_i = ($urandom_range(99) < full_pct);
               @(posedge clk); #1;
            end
            fifo_full_i = 1'b0;
         end
      join
   endtask

   task automatic stream_cont(input int n);
      int   done = 0;
      int   cyc = 0;
      logic took;
      sample_i = SW'($urandom);
      sample_valid_i = 1'b1;
      sent_q.push_back(sample_i);
      while (done < n && cyc < 5000) begin
         @(negedge clk);
         took = sample_ready_o;
         cyc++;
         @(posedge clk); #1;
         if (took) begin
            done++;
            if (done < n) begin
               sample_i = SW'($urandom);
               sent_q.push_back(sample_i);
            end else begin
               sample_valid_i = 1'b0;
            end
         end
      end
      chk("cont_transfers", done, n);
   endtask

   task automatic check_pkt1(input string tag);
      logic [7:0] want[7];
      want[0] = 8'hA5; want[1] = 8'h00; want[2] = 8'h12; want[3] = 8'h34;
      want[4] = 8'hAB; want[5] = 8'hCD;
`ifdef PKT_CRC8_EN
      want[6] = 8'hE3;
`else
      want[6] = 8'hBE;
`endif
      chk({tag, "_nbytes"}, got_q.size(), 32'd7);
      for (int i = 0; i < 7; i++) chk($sformatf("%s_b%0d", tag, i), {24'b0, got_at(i)}, {24'b0, want[i]});
      chk({tag, "_seq"},  {24'b0, seq_o}, 32'd1);
      chk({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sample_i = '0; sample_valid_i = 1'b0; fifo_full_i = 1'b0; stop_full = 1'b0;

      // Directed packet, no stall.
      do_reset();
      send_sample(16'h1234);
      send_sample(16'hABCD);
      wait_done(7);
      check_pkt1("pkt1");
      check_stream("pkt1_model");

      // Five-cycle stall on the SEQ byte.
      do_reset();
      send_sample(16'h1234);            // now in SYNC, which writes this cycle
      @(posedge clk); #1;               // now in SEQ
      fifo_full_i = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("stall_wr_en", {31'b0, wr_en_o}, 32'd0);
         chk("stall_data",  {24'b0, data_o}, 32'd0);
         @(posedge clk); #1;
      end
      chk("stall_nbytes", got_q.size(), 32'd1);
      fifo_full_i = 1'b0;
      send_sample(16'hABCD);
      wait_done(7);
      check_pkt1("stall");

      // 257 packets with random samples and random FIFO-full: SEQ wraps FF -> 00.
      do_reset();
      random_packets(257, 25);
      check_stream("wrap");
      check_samples("wrap_samples");
      chk("wrap_seq255", {24'b0, got_at(255*PKT_LEN + 1)}, 32'hFF);
      chk("wrap_seq256", {24'b0, got_at(256*PKT_LEN + 1)}, 32'h00);
      chk("wrap_seq_o",  {24'b0, seq_o}, 32'd1);

      // Continuously asserted valid: every sample taken exactly once.
      stream_cont(3 * SPP);
      wait_done(257 * PKT_LEN + 3 * PKT_LEN);
      check_stream("cont");
      check_samples("cont_samples");

      // Asynchronous reset in the middle of PAYLOAD.
      do_reset();
      send_sample(16'h1234);
      begin
         int n = 0;
         while (got_q.size() < 3 && n < 100) begin @(posedge clk); #1; n++; end
      end
      chk("mid_pre_wr_en", {31'b0, wr_en_o}, 32'd1);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_wr_en", {31'b0, wr_en_o}, 32'd0);
      chk("mid_rst_ready", {31'b0, sample_ready_o}, 32'd0);
      chk("mid_rst_busy",  {31'b0, busy_o}, 32'd0);
      chk("mid_rst_seq",   {24'b0, seq_o}, 32'd0);
      got_q.delete(); acc_q.delete(); sent_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      send_sample(16'h5555);
      send_sample(16'h6666);
      wait_done(PKT_LEN);
      chk("after_rst_b0", {24'b0, got_at(0)}, 32'hA5);
      chk("after_rst_b1", {24'b0, got_at(1)}, 32'h00);
      check_stream("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
